// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and load/store.
// Splits 1/2/4-byte accesses into little-endian byte cycles and returns assembled data.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter bit          LS_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_signed,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              mem_busy
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [1:0]          size_q, size_nxt;
    logic                we_q, we_nxt;
    logic                sgn_q, sgn_nxt;
    logic [31:0]         wdata_q, wdata_nxt;
    logic                own_ls_q, own_ls_nxt;
    logic [2:0]          cnt_q, cnt_nxt;
    logic [31:0]         data_q, data_nxt;
    logic [ADDR_W-1:0]   mem_a_nxt;
    logic [7:0]          mem_dout_nxt;
    logic                mem_wr_nxt, if_done_nxt, ls_done_nxt, mem_busy_nxt;
    logic [31:0]         if_data_nxt, ls_rdata_nxt;
    logic [1:0]          rd_sel, wr_sel;
    logic                grant_ls, grant_if, last_wr;

    assign grant_ls = ls_req && (LS_PRIO || !if_req);
    assign grant_if = if_req && !grant_ls;
    assign rd_sel   = 2'(cnt_q - 3'd1);
    assign wr_sel   = 2'(cnt_q + 3'd1);
    assign last_wr  = (cnt_q == {1'b0, size_q});

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sg);
        case (sz)
            2'd0:    extend = {{24{sg & d[7]}}, d[7:0]};
            2'd1:    extend = {{16{sg & d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // State register; rdy_in low freezes the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_ls)      state_nxt = ls_we ? WR : RD;
                else if (grant_if) state_nxt = RD;
            end
            RD:   if (cnt_q == {1'b0, size_q} + 3'd1) state_nxt = DONE;
            WR:   if (mem_wr && last_wr) state_nxt = DONE;
            DONE: if (if_done || ls_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of datapath and registered outputs
    always_comb begin
        addr_nxt     = addr_q;
        size_nxt     = size_q;
        we_nxt       = we_q;
        sgn_nxt      = sgn_q;
        wdata_nxt    = wdata_q;
        own_ls_nxt   = own_ls_q;
        cnt_nxt      = cnt_q;
        data_nxt     = data_q;
        mem_a_nxt    = mem_a;
        mem_dout_nxt = mem_dout;
        mem_wr_nxt   = 1'b0;
        if_done_nxt  = 1'b0;
        ls_done_nxt  = 1'b0;
        if_data_nxt  = if_data;
        ls_rdata_nxt = ls_rdata;
        unique case (state)
            IDLE: begin
                if (grant_ls || grant_if) begin
                    own_ls_nxt = grant_ls;
                    addr_nxt   = grant_ls ? ls_addr : if_addr;
                    size_nxt   = grant_ls ? ((ls_size == 2'd2) ? 2'd3 : ls_size) : 2'd3;
                    we_nxt     = grant_ls && ls_we;
                    sgn_nxt    = grant_ls && ls_signed;
                    wdata_nxt  = ls_wdata;
                    cnt_nxt    = 3'd0;
                    data_nxt   = 32'd0;
                    mem_a_nxt  = addr_nxt;
                    if (we_nxt) begin
                        mem_dout_nxt = ls_wdata[7:0];
                        mem_wr_nxt   = 1'b1;
                    end
                end
            end
            RD: begin
                // Address runs one cycle ahead of mem_din, so capture lags issue by two
                cnt_nxt = cnt_q + 3'd1;
                if (cnt_q < {1'b0, size_q}) mem_a_nxt = addr_q + ADDR_W'(cnt_nxt);
                if (cnt_q != 3'd0) data_nxt[{rd_sel, 3'b000} +: 8] = mem_din;
                if (cnt_q == {1'b0, size_q} + 3'd1) begin
                    if (own_ls_q) begin
                        ls_rdata_nxt = extend(data_nxt, size_q, sgn_q);
                        ls_done_nxt  = 1'b1;
                    end else begin
                        if_data_nxt = data_nxt;
                        if_done_nxt = 1'b1;
                    end
                end
            end
            WR: begin
                // mem_wr low here means a stall dropped the current byte: reissue it
                if (!mem_wr) begin
                    mem_wr_nxt = 1'b1;
                end else if (!last_wr) begin
                    cnt_nxt      = cnt_q + 3'd1;
                    mem_a_nxt    = addr_q + ADDR_W'(cnt_q + 3'd1);
                    mem_dout_nxt = wdata_q[{wr_sel, 3'b000} +: 8];
                    mem_wr_nxt   = 1'b1;
                end else begin
                    ls_done_nxt = 1'b1;
                end
            end
            DONE: begin
                // A stall during DONE swallowed the pulse; present it again
                if (!(if_done || ls_done)) begin
                    if (own_ls_q) ls_done_nxt = 1'b1;
                    else          if_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        mem_busy_nxt = (state_nxt != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            size_q   <= 2'd0;
            we_q     <= 1'b0;
            sgn_q    <= 1'b0;
            wdata_q  <= 32'd0;
            own_ls_q <= 1'b0;
            cnt_q    <= 3'd0;
            data_q   <= 32'd0;
            mem_a    <= '0;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= 32'd0;
            ls_rdata <= 32'd0;
            mem_busy <= 1'b0;
        end else if (rdy_in) begin
            addr_q   <= addr_nxt;
            size_q   <= size_nxt;
            we_q     <= we_nxt;
            sgn_q    <= sgn_nxt;
            wdata_q  <= wdata_nxt;
            own_ls_q <= own_ls_nxt;
            cnt_q    <= cnt_nxt;
            data_q   <= data_nxt;
            mem_a    <= mem_a_nxt;
            mem_dout <= mem_dout_nxt;
            mem_wr   <= mem_wr_nxt;
            if_done  <= if_done_nxt;
            ls_done  <= ls_done_nxt;
            if_data  <= if_data_nxt;
            ls_rdata <= ls_rdata_nxt;
            mem_busy <= mem_busy_nxt;
        end else begin
            mem_wr  <= 1'b0;
            if_done <= 1'b0;
            ls_done <= 1'b0;
        end
    end

endmodule
